// File: rtl/top_float2int.sv
// top_float2int: converts the half-precision float held in data memory
// bytes 64/65 into a 16-bit sign-magnitude integer at bytes 66/67. The
// conversion runs once after each reset release. It steps through the
// states IDLE, LD_HI, LD_LO, CONV, ST_HI, ST_LO and DONE, moving one state
// per clock.

// data_mem: 256 x 8 byte memory. Reads are combinational on the address.
// Writes happen on the rising edge of clk while we is high.
module data_mem (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata
);

   logic [7:0] my_memory [0:255];

   assign rdata = my_memory[addr];

   // Synchronous byte write.
   // NOTE: the array has no reset, so contents preloaded during reset survive it.
   always_ff @(posedge clk) begin
      if (we) begin
         my_memory[addr] <= wdata;
      end
   end

endmodule

module top_float2int (
   input  logic clk,
   input  logic reset,
   output logic done
);

   // State encoding
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LD_HI = 3'd1;
   localparam logic [2:0] LD_LO = 3'd2;
   localparam logic [2:0] CONV  = 3'd3;
   localparam logic [2:0] ST_HI = 3'd4;
   localparam logic [2:0] ST_LO = 3'd5;
   localparam logic [2:0] DONE  = 3'd6;

   // Memory map of operand and result bytes
   localparam logic [7:0] ADDR_OP_HI  = 8'd64;
   localparam logic [7:0] ADDR_OP_LO  = 8'd65;
   localparam logic [7:0] ADDR_RES_HI = 8'd66;
   localparam logic [7:0] ADDR_RES_LO = 8'd67;

   // Half-precision field boundaries, expressed on the biased exponent E
   localparam logic [4:0] EXP_BIAS    = 5'd15;  // e = 0
   localparam logic [4:0] EXP_UNITY   = 5'd25;  // e = 10, m used unshifted
   localparam logic [4:0] EXP_SAT     = 5'd30;  // e = 15, first saturating value

   logic [2:0]  state;
   logic [2:0]  state_next;
   logic [15:0] operand;
   logic [15:0] result;
   logic [15:0] conv_value;

   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic        op_sign;
   logic [4:0]  op_exp;
   logic [10:0] op_mant;
   logic [14:0] mag;

   data_mem data_mem1 (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   // Next-state logic: a fixed walk through the sequence, holding in DONE.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = LD_HI;
         LD_HI:   state_next = LD_LO;
         LD_LO:   state_next = CONV;
         CONV:    state_next = ST_HI;
         ST_HI:   state_next = ST_LO;
         ST_LO:   state_next = DONE;
         DONE:    state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // Memory port control. The address is steered by the state. Writes are
   // gated by reset so that an abort takes effect on the same edge.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = ADDR_OP_HI;
      mem_wdata = 8'h00;
      case (state)
         LD_HI: mem_addr = ADDR_OP_HI;
         LD_LO: mem_addr = ADDR_OP_LO;
         ST_HI: begin
            mem_we    = ~reset;
            mem_addr  = ADDR_RES_HI;
            mem_wdata = result[15:8];
         end
         ST_LO: begin
            mem_we    = ~reset;
            mem_addr  = ADDR_RES_LO;
            mem_wdata = result[7:0];
         end
         default: begin
            mem_we    = 1'b0;
            mem_addr  = ADDR_OP_HI;
            mem_wdata = 8'h00;
         end
      endcase
   end

   // Float-to-integer datapath: decode, shift or saturate, then suppress -0.
   always_comb begin
      op_sign = operand[15];
      op_exp  = operand[14:10];
      op_mant = {(op_exp != 5'd0), operand[9:0]};
      mag     = 15'd0;
      if (op_exp < EXP_BIAS) begin
         // |value| < 1; this also covers zero and denormals.
         mag = 15'd0;
      end else if (op_exp >= EXP_SAT) begin
         // Too large for 15 bits, or inf/NaN.
         mag = 15'h7FFF;
      end else if (op_exp >= EXP_UNITY) begin
         // Left shift by at most 4. 2047 << 4 = 32752 still fits in 15 bits.
         mag = {4'b0000, op_mant} << (op_exp - EXP_UNITY);
      end else begin
         // Right shift. Fraction bits fall off, which truncates toward zero.
         mag = {4'b0000, op_mant >> (EXP_UNITY - op_exp)};
      end
      conv_value = {op_sign & (mag != 15'd0), mag};
   end

   // State and operand/result registers, cleared by the synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         operand <= 16'h0000;
         result  <= 16'h0000;
      end else begin
         state <= state_next;
         case (state)
            LD_HI:   operand[15:8] <= mem_rdata;
            LD_LO:   operand[7:0]  <= mem_rdata;
            CONV:    result        <= conv_value;
            default: ;
         endcase
      end
   end

   assign done = (state == DONE);

endmodule

// File: tb/tb_top_float2int.sv
// tb_top_float2int: scoreboard bench for top_float2int. Before each reset
// release the stimulus pushes the expected result into a queue. A separate
// monitor pops an entry on every rising edge of done and compares the result
// bytes and the done latency against it.
module tb_top_float2int;

   logic clk;
   logic reset;
   logic done;

   int   checks;
   int   errors;
   int   cyc;
   int   n_seen;
   logic done_prev;

   logic [15:0] exp_q [$];
   int          rel_q [$];

   top_float2int dut (
      .clk   (clk),
      .reset (reset),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Reference model, written directly from the arithmetic definition.
   function automatic logic [15:0] model(input logic [15:0] f);
      int e;
      int m;
      int mg;
      e = int'(f[14:10]) - 15;
      m = (f[14:10] != 5'd0) ? 1024 + int'(f[9:0]) : int'(f[9:0]);
      if (e < 0)        mg = 0;
      else if (e >= 15) mg = 32767;
      else if (e >= 10) mg = m * (1 << (e - 10));
      else              mg = m / (1 << (10 - e));
      return {(f[15] && mg != 0), mg[14:0]};
   endfunction

   // Monitor: each rising edge of done must match the oldest expected entry.
   always @(negedge clk) begin
      if (done && !done_prev) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [15:0] exp_r;
            int          rel;
            exp_r = exp_q.pop_front();
            rel   = rel_q.pop_front();
            check("result", {dut.data_mem1.my_memory[66], dut.data_mem1.my_memory[67]}, exp_r);
            check("done_latency", cyc - rel, 6);
         end
         n_seen++;
      end
      done_prev = done;
   end

   task automatic preload(input logic [15:0] op);
      dut.data_mem1.my_memory[64] = op[15:8];
      dut.data_mem1.my_memory[65] = op[7:0];
      dut.data_mem1.my_memory[66] = 8'hA5;
      dut.data_mem1.my_memory[67] = 8'h5A;
   endtask

   task automatic run_conv(input logic [15:0] op, input logic [15:0] exp_r);
      int start;
      bit seen;
      @(negedge clk);
      reset = 1'b1;
      preload(op);
      @(negedge clk);
      @(negedge clk);
      exp_q.push_back(exp_r);
      rel_q.push_back(cyc);
      start = n_seen;
      reset = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (n_seen != start) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         check("done_timeout", 32'd0, 32'd1);
         if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            void'(rel_q.pop_front());
         end
      end
      repeat (3) @(negedge clk);
      check("done_hold", done, 1'b1);
      check("result_hold", {dut.data_mem1.my_memory[66], dut.data_mem1.my_memory[67]}, exp_r);
   endtask

   typedef struct {
      logic [15:0] op;
      logic [15:0] res;
   } vec_t;

   vec_t vecs [$];

   initial begin
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      n_seen    = 0;
      done_prev = 1'b0;
      reset     = 1'b1;

      // Reset state, and memory preserved across reset.
      dut.data_mem1.my_memory[64] = 8'h3C;
      repeat (3) @(negedge clk);
      check("reset_done", done, 1'b0);
      check("reset_operand", dut.operand, 16'h0000);
      check("reset_result", dut.result, 16'h0000);
      check("reset_mem_keep", dut.data_mem1.my_memory[64], 8'h3C);

      // Directed vectors with hand-computed results.
      vecs.push_back('{16'hC204, 16'h8003});
      vecs.push_back('{16'hCA10, 16'h800C});
      vecs.push_back('{16'hD20F, 16'h8030});
      vecs.push_back('{16'h7800, 16'h7FFF});
      vecs.push_back('{16'h7C00, 16'h7FFF});
      vecs.push_back('{16'hF800, 16'hFFFF});
      vecs.push_back('{16'h77FF, 16'h7FF0});
      vecs.push_back('{16'h3BFF, 16'h0000});
      vecs.push_back('{16'hB800, 16'h0000});
      vecs.push_back('{16'h3C00, 16'h0001});
      vecs.push_back('{16'h0001, 16'h0000});
      vecs.push_back('{16'hFE01, 16'hFFFF});
      vecs.push_back('{16'h6400, 16'h0400});
      foreach (vecs[i]) run_conv(vecs[i].op, vecs[i].res);

      // Abort: reset returns before the ST_HI write edge.
      @(negedge clk);
      reset = 1'b1;
      preload(16'h4A00);
      dut.data_mem1.my_memory[67] = 8'h3C;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      check("abort_done", done, 1'b0);
      check("abort_mem67", dut.data_mem1.my_memory[67], 8'h3C);
      run_conv(16'hC500, 16'h8005);

      // Random operands checked against the model.
      for (int i = 0; i < 24; i++) begin
         logic [15:0] op;
         op = 16'($urandom);
         run_conv(op, model(op));
      end

      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
